// File: rtl/counter_sequencer.sv
// Single-clock sequencer for the mod-N 7-segment counter: button step/pause, prescaled auto-count, count register.
// Define CNT_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES debounce filter after the button synchronizer.
module counter_sequencer #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned PRESCALE        = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_step,
    input  logic             run_sw,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             tick,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_MANUAL = 2'b00,
        S_AUTO   = 2'b01,
        S_PAUSE  = 2'b10
    } state_t;

    localparam int unsigned   PW            = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] count_d;
    logic             wrap_d;
    logic             advance;
    logic             sync1, sync2;
    logic             btn_level, edge_ref, step_p;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_step;
            sync2 <= sync1;
        end
    end

`ifdef CNT_DEBOUNCE_EN
    localparam int unsigned   DW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [DW-1:0] deb_cnt;
    logic          deb_level;

    // Counter restarts whenever the synchronized level agrees with the filtered one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_cnt   <= '0;
            deb_level <= 1'b0;
        end else if (sync2 == deb_level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            deb_cnt   <= '0;
            deb_level <= sync2;
        end else begin
            deb_cnt <= deb_cnt + DW'(1);
        end
    end

    assign btn_level = deb_level;
`else
    localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign btn_level = sync2;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_ref <= 1'b0;
        end else begin
            edge_ref <= btn_level;
        end
    end

    assign step_p = btn_level & ~edge_ref;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_MANUAL;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        tick    = 1'b0;
        presc_d = '0;
        case (state_q)
            S_MANUAL: begin
                advance = step_p;
                if (run_sw) begin
                    state_d = S_AUTO;
                end
            end
            S_AUTO: begin
                tick    = (presc_q == PRESCALE_LAST);
                advance = tick;
                if (!run_sw) begin
                    state_d = S_MANUAL;
                end else if (step_p) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (!run_sw) begin
                    state_d = S_MANUAL;
                end else if (step_p) begin
                    state_d = S_AUTO;
                end
            end
            default: state_d = S_MANUAL;
        endcase
        // Prescaler only runs while staying in auto, so every entry into auto restarts from 0.
        if (state_q == S_AUTO && state_d == S_AUTO && !tick) begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_comb begin
        count_d = count;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = (load_val > max_val) ? max_val : load_val;
        end else if (advance) begin
            if (up_down) begin
                if (count >= max_val) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count + WIDTH'(1);
                end
            end else if (count == '0 || count > max_val) begin
                count_d = max_val;
                wrap_d  = 1'b1;
            end else begin
                count_d = count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_d;
            wrap  <= wrap_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer (default build, CNT_DEBOUNCE_EN undefined).
module tb_counter_sequencer;

    localparam int W  = 4;
    localparam int PS = 4;

    logic         clk = 1'b0;
    logic         reset, btn_step, run_sw, up_down, load;
    logic [W-1:0] load_val, max_val, count;
    logic         wrap, tick;
    logic [1:0]   state;

    int checks    = 0;
    int failures  = 0;
    int wrap_seen = 0;
    bit cmp_en    = 0;

    counter_sequencer #(.WIDTH(W), .PRESCALE(PS), .DEBOUNCE_CYCLES(3)) dut (
        .clk(clk), .reset(reset), .btn_step(btn_step), .run_sw(run_sw),
        .up_down(up_down), .load(load), .load_val(load_val), .max_val(max_val),
        .count(count), .wrap(wrap), .tick(tick), .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 manual, 1 auto, 2 paused; m_age = cycles spent in auto since entry, mod PS.
    int m_count = 0;
    int m_mode  = 0;
    int m_age   = 0;
    bit m_wrap  = 0;
    bit hist[3] = '{default: 1'b0};

    function automatic bit m_tick();
        return (m_mode == 1) && (m_age == PS - 1);
    endfunction

    always @(posedge clk or posedge reset) begin
        bit step, adv;
        int nmode, mv;
        if (reset) begin
            m_count = 0; m_mode = 0; m_age = 0; m_wrap = 0;
            hist = '{default: 1'b0};
        end else begin
            // A press is seen two samples after the first high sample that followed a low one.
            step  = hist[1] && !hist[2];
            adv   = (m_mode == 0 && step) || m_tick();
            if (m_mode == 0)      nmode = run_sw ? 1 : 0;
            else if (m_mode == 1) nmode = !run_sw ? 0 : (step ? 2 : 1);
            else                  nmode = !run_sw ? 0 : (step ? 1 : 2);
            mv     = int'(max_val);
            m_wrap = 0;
            if (load) begin
                m_count = (int'(load_val) > mv) ? mv : int'(load_val);
            end else if (adv) begin
                if (up_down) begin
                    if (m_count >= mv) begin m_count = 0; m_wrap = 1; end
                    else m_count = m_count + 1;
                end else begin
                    if (m_count == 0 || m_count > mv) begin m_count = mv; m_wrap = 1; end
                    else m_count = m_count - 1;
                end
            end
            m_age  = (m_mode == 1 && nmode == 1) ? (m_age + 1) % PS : 0;
            m_mode = nmode;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = btn_step;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            check("cmp_count", count, m_count);
            check("cmp_wrap",  wrap,  m_wrap);
            check("cmp_tick",  tick,  m_tick());
            check("cmp_state", state, m_mode);
        end
        if (!reset && wrap === 1'b1) wrap_seen++;
    end

    task automatic step_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press();
        btn_step = 1'b1;
        step_cycles(2);
        btn_step = 1'b0;
        step_cycles(3);
    endtask

    task automatic load_value(input int v);
        load = 1'b1;
        load_val = W'(v);
        step_cycles(1);
        load = 1'b0;
    endtask

    int w0;
    int seq[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    bit pattern[14] = '{1, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};

    initial begin
        reset = 1'b1; btn_step = 1'b0; run_sw = 1'b0; up_down = 1'b1;
        load = 1'b0; load_val = '0; max_val = W'(7);
        step_cycles(2);
        check("reset_count", count, 0);
        check("reset_state", state, 0);
        check("reset_wrap",  wrap,  0);
        check("reset_tick",  tick,  0);
        reset = 1'b0;
        cmp_en = 1'b1;

        // Manual up-count through the wrap.
        w0 = wrap_seen;
        for (int i = 0; i < 9; i++) begin
            press();
            check("manual_up_count", count, seq[i]);
        end
        check("manual_up_wraps", wrap_seen - w0, 1);

        // Down-count wrap from 0 to max.
        up_down = 1'b0; max_val = W'(5);
        load_value(0);
        w0 = wrap_seen;
        press();
        check("down_wrap_count", count, 5);
        check("down_wrap_pulses", wrap_seen - w0, 1);
        press();
        check("down_count", count, 4);
        check("down_no_wrap", wrap_seen - w0, 1);

        // Auto mode, pause, resume.
        up_down = 1'b1; max_val = W'(15);
        load_value(0);
        run_sw = 1'b1;
        step_cycles(1);
        check("auto_state", state, 1);
        step_cycles(12);
        check("auto_count", count, 3);
        press();
        check("pause_state", state, 2);
        step_cycles(20);
        check("pause_frozen", count, 3);
        press();
        check("resume_state", state, 1);
        check("resume_count", count, 3);
        step_cycles(1);
        check("resume_tick", tick, 1);
        step_cycles(1);
        check("resume_advance", count, 4);

        // Load coinciding with a tick.
        for (int i = 0; i < 20 && tick !== 1'b1; i++) step_cycles(1);
        check("tick_wait", tick, 1);
        max_val = W'(7);
        load_value(9);
        check("load_tick_count", count, 7);
        check("load_tick_wrap",  wrap,  0);
        check("load_tick_state", state, 1);

        // Asynchronous reset in auto mode.
        load_value(5);
        check("pre_reset_count", count, 5);
        #1 reset = 1'b1;
        #1;
        check("async_reset_count", count, 0);
        check("async_reset_state", state, 0);
        step_cycles(1);
        reset = 1'b0;
        step_cycles(1);
        check("post_reset_state", state, 1);

        // Single-cycle glitches without debounce count as presses.
        run_sw = 1'b0; max_val = W'(15);
        step_cycles(1);
        load_value(0);
        for (int i = 0; i < 14; i++) begin
            btn_step = pattern[i];
            step_cycles(1);
        end
        btn_step = 1'b0;
        step_cycles(3);
        check("glitch_advances", count, 3);

        // Randomized operation against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0)   btn_step = ~btn_step;
            if ($urandom_range(0, 39) == 0)  run_sw = ~run_sw;
            if ($urandom_range(0, 19) == 0)  up_down = ~up_down;
            load = ($urandom_range(0, 24) == 0);
            load_val = W'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0)
                max_val = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                step_cycles(1);
                reset = 1'b0;
            end
            step_cycles(1);
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
